// File: rtl/rd_sched_pkg.sv
// rd_sched_pkg: burst codes, window lengths, FSM encoding and settings layout for the read scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rd_sched_pkg;

  localparam logic [1:0] BL16 = 2'b00;
  localparam logic [1:0] BC8  = 2'b01;
  localparam logic [1:0] BL32 = 2'b10;

  localparam logic [4:0] CYC_BL16 = 5'd8;
  localparam logic [4:0] CYC_BC8  = 5'd4;
  localparam logic [4:0] CYC_BL32 = 5'd16;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam int SETT_W = 8;

  // Per-burst settings as queued and as presented to data_manager.
  typedef struct packed {
    logic [2:0] pre_amble;
    logic [1:0] bl;
    logic       post_amble;
    logic       crc_en;
    logic       crc_mode;
  } rd_sett_t;

  // Window length in cycles; the reserved code 11 behaves like BL16, CRC adds one beat.
  function automatic logic [4:0] burst_len(input logic [1:0] bl, input logic crc_en);
    logic [4:0] len;
    case (bl)
      BL16:    len = CYC_BL16;
      BC8:     len = CYC_BC8;
      BL32:    len = CYC_BL32;
      default: len = CYC_BL16;
    endcase
    return len + {4'd0, crc_en};
  endfunction

endpackage

// File: rtl/rd_cmd_fifo.sv
// rd_cmd_fifo: DEPTH x W first-word-fall-through queue with synchronous flush.
// Latency: pushed word is visible on pop_dat_o the edge after the push.
// Backpressure: pushes while full and pops while empty are ignored; full_o is registered.
module rd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full_o    = (r_cnt == CW'(DEPTH));
  assign empty_o   = (r_cnt == '0);
  assign w_push    = push_i && !full_o;
  assign w_pop     = pop_i && !empty_o;
  assign pop_dat_o = r_mem[r_rd];

  // Storage array; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= push_dat_i;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rd_cmd_scheduler.sv
// rd_cmd_scheduler: queues read commands and opens dfi_rddata_en windows with per-burst settings; RD_SCHED_PERF_EN adds pop/seamless counters.
// Latency: window opens max(rddata_en_lat_i,1) edges after accept; due bursts follow each other with zero gap.
// Backpressure: cmd_ready_o low while the DEPTH-entry queue is full or en_i is low; en_i low flushes everything pending.
module rd_cmd_scheduler
  import rd_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_LAT = 32
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic [4:0] rddata_en_lat_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_pre_amble_i,
  input  logic [1:0] cmd_bl_i,
  input  logic       cmd_post_amble_i,
  input  logic       cmd_crc_en_i,
  input  logic       cmd_crc_mode_i,
  output logic       dfi_rddata_en_o,
  output logic [2:0] pre_amble_sett_o,
  output logic [1:0] bl_o,
  output logic       post_amble_sett_o,
  output logic       read_crc_enable_o,
  output logic       phy_crc_mode_o,
  output logic       idle_o,
  output logic       collision_o
`ifdef RD_SCHED_PERF_EN
  ,
  output logic [15:0] burst_cnt_o,
  output logic [15:0] seamless_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [MAX_LAT-1:0] r_dly;
  logic [CW-1:0]      r_due;
  logic [0:0]         r_state;
  logic [4:0]         r_cnt;
  logic               r_run;
  logic               r_coll;
  rd_sett_t           r_sett;

  rd_sett_t           w_in;
  rd_sett_t           w_head;
  logic [SETT_W-1:0]  w_head_dat;
  logic               w_full;
  logic               w_empty;
  logic [4:0]         w_tap;
  logic [5:0]         w_clr_pos;
  logic [MAX_LAT-1:0] w_dly_nxt;
  logic               w_exit;
  logic               w_push;
  logic               w_pop;
  logic               w_seam;
  logic               w_coll;

  assign w_in.pre_amble  = cmd_pre_amble_i;
  assign w_in.bl         = cmd_bl_i;
  assign w_in.post_amble = cmd_post_amble_i;
  assign w_in.crc_en     = cmd_crc_en_i;
  assign w_in.crc_mode   = cmd_crc_mode_i;
  assign w_head          = w_head_dat;

  // r_run keeps ready low while reset is asserted and for the first edge after it.
  assign cmd_ready_o = r_run && en_i && !w_full;
  assign w_push      = cmd_valid_i && cmd_ready_o;

  // Marker pushed into bit 0 sits at bit L-1 in the cycle before its L-th edge.
  assign w_tap     = (rddata_en_lat_i == 5'd0) ? 5'd0 : rddata_en_lat_i - 5'd1;
  assign w_exit    = r_dly[w_tap];
  // Exiting markers are cleared so the line only ever holds pending ones.
  assign w_clr_pos = {1'b0, w_tap} + 6'd1;
  assign w_dly_nxt = {r_dly[MAX_LAT-2:0], w_push} & ~(MAX_LAT'(1) << w_clr_pos);

  assign w_pop  = en_i && ((r_due != '0) || w_exit) &&
                  ((r_state == ST_IDLE) || (r_cnt == 5'd0));
  assign w_seam = w_pop && (r_state == ST_ACTIVE);
  assign w_coll = en_i && w_exit && (r_state == ST_ACTIVE) && (r_cnt != 5'd0);

  rd_cmd_fifo #(.DEPTH(DEPTH), .W(SETT_W)) u_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .flush_i    (!en_i),
    .push_i     (w_push),
    .push_dat_i (w_in),
    .pop_i      (w_pop),
    .pop_dat_o  (w_head_dat),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

  // Reset-release qualifier for cmd_ready_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_run <= 1'b0;
    else            r_run <= 1'b1;
  end

  // Latency delay line and count of launches that are due but not yet popped.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dly <= '0;
      r_due <= '0;
    end else if (!en_i) begin
      r_dly <= '0;
      r_due <= '0;
    end else begin
      r_dly <= w_dly_nxt;
      case ({w_exit, w_pop})
        2'b10:   r_due <= r_due + CW'(1);
        2'b01:   r_due <= r_due - CW'(1);
        default: r_due <= r_due;
      endcase
    end
  end

  // Window FSM: a pop (re)loads the beat counter, ACTIVE ends when it hits zero with nothing due.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
    end else if (!en_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
    end else if (w_pop) begin
      r_state <= ST_ACTIVE;
      r_cnt   <= burst_len(w_head.bl, w_head.crc_en) - 5'd1;
    end else if (r_state == ST_ACTIVE) begin
      if (r_cnt == 5'd0) r_state <= ST_IDLE;
      else               r_cnt   <= r_cnt - 5'd1;
    end
  end

  // Settings follow the popped command and are held otherwise, including across a flush.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_sett <= '0;
    else if (w_pop)  r_sett <= w_head;
  end

  // Sticky flag: a launch came due while the previous window was still running.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_coll <= 1'b0;
    else if (w_coll) r_coll <= 1'b1;
  end

  assign dfi_rddata_en_o   = (r_state == ST_ACTIVE);
  assign pre_amble_sett_o  = r_sett.pre_amble;
  assign bl_o              = r_sett.bl;
  assign post_amble_sett_o = r_sett.post_amble;
  assign read_crc_enable_o = r_sett.crc_en;
  assign phy_crc_mode_o    = r_sett.crc_mode;
  assign idle_o            = w_empty && (r_dly == '0) && (r_state == ST_IDLE);
  assign collision_o       = r_coll;

`ifdef RD_SCHED_PERF_EN
  logic [15:0] r_burst_cnt;
  logic [15:0] r_seam_cnt;

  // Saturating counts of pops and of zero-gap reloads.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_burst_cnt <= 16'd0;
      r_seam_cnt  <= 16'd0;
    end else if (!en_i) begin
      r_burst_cnt <= 16'd0;
      r_seam_cnt  <= 16'd0;
    end else begin
      if (w_pop && (r_burst_cnt != 16'hFFFF)) r_burst_cnt <= r_burst_cnt + 16'd1;
      if (w_seam && (r_seam_cnt != 16'hFFFF)) r_seam_cnt  <= r_seam_cnt + 16'd1;
    end
  end

  assign burst_cnt_o    = r_burst_cnt;
  assign seamless_cnt_o = r_seam_cnt;
`else
  // Default build carries no counters; w_seam only feeds them.
  logic w_seam_unused;
  assign w_seam_unused = w_seam;
`endif

endmodule
